spi_arb: RTL and testbench

SPI_ARB -- requirements
Module: spi_arb

---
 rtl/spi_arb.sv | 140 ++++++++++++++
 tb/tb_spi_arb.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/spi_arb.sv
// spi_arb: round-robin arbiter that lets NREQ requesters share one SPI master.
// A request is taken in IDLE, issued as a one-cycle m_start, tracked until
// m_done or a timeout, and completed with a one-cycle ack to the granted
// requester.
module spi_arb #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int TMO  = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_din,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    ack,
    output logic               err,
    output logic [DW-1:0]      rsp_dout,
    output logic               m_start,
    output logic [DW-1:0]      m_din,
    input  logic               m_done,
    input  logic [DW-1:0]      m_dout
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(TMO);
    // Counter value in the last WAIT cycle before expiry: the counter reaches
    // TMO-1 on that edge, so the ack lands exactly TMO cycles after m_start.
    localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 2);
    localparam logic [PW-1:0] SEL_MAX  = PW'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     sel_q, sel_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              err_q, err_d;
    logic [DW-1:0]     rsp_q, rsp_d;
    logic [DW-1:0]     din_q, din_d;

    logic              pick_found;
    logic [PW-1:0]     pick_idx;
    int                cand;

    // Round-robin search: first set req bit at or above ptr, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(ptr_q) + k) % NREQ;
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand[PW-1:0];
            end
        end
    end

    // Next-state and datapath decisions for the transaction FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        err_d   = 1'b0;
        rsp_d   = rsp_q;
        din_d   = din_q;
        unique case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    sel_d   = pick_idx;
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                    din_d   = req_din[pick_idx*DW +: DW];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // Completion takes priority over a coincident timeout.
                if (m_done) begin
                    rsp_d   = m_dout;
                    state_d = S_ACK;
                end else if (cnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                gnt_d   = '0;
                ptr_d   = (sel_q == SEL_MAX) ? '0 : sel_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            err_q   <= 1'b0;
            rsp_q   <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            err_q   <= err_d;
            rsp_q   <= rsp_d;
            din_q   <= din_d;
        end
    end

    assign gnt      = gnt_q;
    assign ack      = (state_q == S_ACK) ? gnt_q : '0;
    assign err      = err_q;
    assign rsp_dout = rsp_q;
    assign m_start  = (state_q == S_ISSUE);
    assign m_din    = din_q;

endmodule

// File: tb/tb_spi_arb.sv
// Directed bench for spi_arb: single transfer, round robin, stray m_done,
// reset mid-transfer, and timeout / completion-at-expiry on a TMO=16 instance.
module tb_spi_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req, req_t;
    logic [31:0] req_din;
    logic        m_done, m_done_t;
    logic [7:0]  m_dout;

    logic [3:0]  gnt, ack, gnt_t, ack_t;
    logic        err, err_t, m_start, m_start_t;
    logic [7:0]  rsp_dout, rsp_dout_t, m_din, m_din_t;

    int n_cmp = 0;
    int n_bad = 0;

    spi_arb dut (
        .clk(clk), .reset(reset), .req(req), .req_din(req_din),
        .gnt(gnt), .ack(ack), .err(err), .rsp_dout(rsp_dout),
        .m_start(m_start), .m_din(m_din), .m_done(m_done), .m_dout(m_dout)
    );

    spi_arb #(.NREQ(4), .DW(8), .TMO(16)) dut_t (
        .clk(clk), .reset(reset), .req(req_t), .req_din(req_din),
        .gnt(gnt_t), .ack(ack_t), .err(err_t), .rsp_dout(rsp_dout_t),
        .m_start(m_start_t), .m_din(m_din_t), .m_done(m_done_t), .m_dout(m_dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction on the default instance, starting in IDLE.
    // m_done is raised d cycles after the m_start cycle.
    task automatic run_txn(input string tag, input logic [3:0] rq, input logic [3:0] exp_gnt,
                           input logic [7:0] exp_din, input int d, input logic [7:0] dout,
                           input logic [3:0] rq_after);
        req = rq;
        tick();
        check({tag, ".m_start"}, 32'(m_start), 1);
        check({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
        check({tag, ".m_din"}, 32'(m_din), 32'(exp_din));
        req = rq_after;
        repeat (d) tick();
        check({tag, ".wait_ack"}, 32'(ack), 0);
        check({tag, ".wait_start"}, 32'(m_start), 0);
        m_done = 1'b1;
        m_dout = dout;
        tick();
        m_done = 1'b0;
        check({tag, ".ack"}, 32'(ack), 32'(exp_gnt));
        check({tag, ".err"}, 32'(err), 0);
        check({tag, ".rsp"}, 32'(rsp_dout), 32'(dout));
        tick();
        check({tag, ".ack_off"}, 32'(ack), 0);
        check({tag, ".gnt_off"}, 32'(gnt), 0);
    endtask

    initial begin
        reset    = 1'b1;
        req      = '0;
        req_t    = '0;
        req_din  = '0;
        m_done   = 1'b0;
        m_done_t = 1'b0;
        m_dout   = '0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        check("rst.gnt", 32'(gnt), 0);
        check("rst.ack", 32'(ack), 0);
        check("rst.err", 32'(err), 0);
        check("rst.m_start", 32'(m_start), 0);
        check("rst.m_din", 32'(m_din), 0);
        check("rst.rsp", 32'(rsp_dout), 0);

        // Single request, m_done 20 cycles after m_start
        req_din = {8'h44, 8'h33, 8'h22, 8'hA5};
        run_txn("single", 4'b0001, 4'b0001, 8'hA5, 20, 8'h3C, 4'b0000);

        // req_din changes after sampling leave m_din alone
        req_din = {8'h44, 8'h33, 8'h22, 8'h11};
        tick();
        check("hold.m_din", 32'(m_din), 32'h A5);

        // Round robin from ptr 0 with all requests held
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run_txn("rr0", 4'b1111, 4'b0001, 8'h11, 5, 8'hC0, 4'b1111);
        run_txn("rr1", 4'b1111, 4'b0010, 8'h22, 5, 8'hC1, 4'b1111);
        run_txn("rr2", 4'b1111, 4'b0100, 8'h33, 5, 8'hC2, 4'b1111);
        run_txn("rr3", 4'b1111, 4'b1000, 8'h44, 5, 8'hC3, 4'b1111);
        run_txn("rr4", 4'b1111, 4'b0001, 8'h11, 5, 8'hC4, 4'b0000);

        // Stray m_done in IDLE
        m_done = 1'b1;
        m_dout = 8'hEE;
        tick();
        m_done = 1'b0;
        check("stray.ack", 32'(ack), 0);
        check("stray.gnt", 32'(gnt), 0);
        check("stray.m_start", 32'(m_start), 0);
        check("stray.rsp", 32'(rsp_dout), 32'h C4);
        tick();
        check("stray.ack2", 32'(ack), 0);
        check("stray.rsp2", 32'(rsp_dout), 32'h C4);

        // Reset in the middle of WAIT, then the late m_done
        req = 4'b0100;
        tick();
        check("midrst.gnt", 32'(gnt), 32'b0100);
        req = 4'b0000;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst.gnt0", 32'(gnt), 0);
        check("midrst.ack0", 32'(ack), 0);
        check("midrst.err0", 32'(err), 0);
        check("midrst.start0", 32'(m_start), 0);
        check("midrst.din0", 32'(m_din), 0);
        check("midrst.rsp0", 32'(rsp_dout), 0);
        m_done = 1'b1;
        m_dout = 8'h99;
        tick();
        m_done = 1'b0;
        check("late.ack", 32'(ack), 0);
        check("late.rsp", 32'(rsp_dout), 0);
        tick();
        check("late.ack2", 32'(ack), 0);
        check("late.start", 32'(m_start), 0);
        run_txn("after_rst", 4'b1000, 4'b1000, 8'h44, 3, 8'h5D, 4'b0000);
        // ptr wrapped from 3 to 0, so requester 0 wins over 1
        run_txn("wrap", 4'b0011, 4'b0001, 8'h11, 2, 8'h6E, 4'b0000);

        // TMO=16 instance: m_done on the expiry cycle completes normally
        req_t = 4'b0100;
        tick();
        check("edge.m_start", 32'(m_start_t), 1);
        check("edge.gnt", 32'(gnt_t), 32'b0100);
        check("edge.m_din", 32'(m_din_t), 32'h 33);
        req_t = 4'b0000;
        repeat (15) tick();
        check("edge.pre_ack", 32'(ack_t), 0);
        m_done_t = 1'b1;
        m_dout   = 8'h77;
        tick();
        m_done_t = 1'b0;
        check("edge.ack", 32'(ack_t), 32'b0100);
        check("edge.err", 32'(err_t), 0);
        check("edge.rsp", 32'(rsp_dout_t), 32'h 77);
        tick();
        check("edge.ack_off", 32'(ack_t), 0);

        // TMO=16 instance: no m_done, ack with err 16 cycles after m_start
        req_t = 4'b0100;
        tick();
        check("tmo.m_start", 32'(m_start_t), 1);
        check("tmo.gnt", 32'(gnt_t), 32'b0100);
        req_t = 4'b0000;
        repeat (15) tick();
        check("tmo.pre_ack", 32'(ack_t), 0);
        check("tmo.pre_err", 32'(err_t), 0);
        tick();
        check("tmo.ack", 32'(ack_t), 32'b0100);
        check("tmo.err", 32'(err_t), 1);
        check("tmo.rsp", 32'(rsp_dout_t), 32'h 77);
        tick();
        check("tmo.ack_off", 32'(ack_t), 0);
        check("tmo.err_off", 32'(err_t), 0);
        check("tmo.gnt_off", 32'(gnt_t), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
